sram_access_ctrl: RTL

Memory-stage controller that sequences every load/store leaving the EXE/MEM pipeline register onto an external 16-bit asynchronous SRAM. Each 32-bit access is split into two half-word phases with programmable wait states. `o_Freeze` holds the pipeline registers (PC, IF/ID, ID/EXE, EXE/MEM) until the access completes. The block sits between the EXE/MEM register outputs and the MEM/WB register inputs and replaces the single-cycle data memory.

---
 rtl/arm_pkg.sv | 7 +
 rtl/sram_access_ctrl_wait_counter.sv | 25 ++
 rtl/sram_access_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the memory-stage SRAM access controller.
package arm_pkg;
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} sram_state_t;

    localparam int SRAM_DATA_WIDTH   = 16;
    localparam int DEFAULT_BASE_ADDR = 1024;
endpackage

// File: rtl/sram_access_ctrl_wait_counter.sv
// Wait-state counter: flags the last cycle of a half-word phase.
module wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Terminal
);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (i_Clear)
            count <= '0;
        else if (i_Enable)
            count <= count + 1'b1;
    end

    assign o_Terminal = (count == CW'(WAIT_CYCLES));
endmodule

// File: rtl/sram_access_ctrl.sv
// Splits each 32-bit load/store into two half-word SRAM phases with wait
// states, freezing the pipeline until the access has completed.
module sram_access_ctrl
    import arm_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 18,
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_Sig_Memory_Read_Enable,
    input  logic                       i_Sig_Memory_Write_Enable,
    input  logic [DATA_WIDTH-1:0]      i_Address,
    input  logic [DATA_WIDTH-1:0]      i_Write_Data,
    output logic [DATA_WIDTH-1:0]      o_Read_Data,
    output logic                       o_Freeze,
    output logic [ADDR_WIDTH-1:0]      o_SRAM_Address,
    output logic                       o_SRAM_Write_Enable_N,
    output logic [SRAM_DATA_WIDTH-1:0] o_SRAM_Data_Out,
    output logic                       o_SRAM_Data_Oe,
    input  logic [SRAM_DATA_WIDTH-1:0] i_SRAM_Data_In
);
    sram_state_t state, state_nxt;

    logic                       req, in_phase, terminal;
    logic [DATA_WIDTH-1:0]      addr_offset;
    logic [ADDR_WIDTH-2:0]      word_in, acc_word;
    logic [SRAM_DATA_WIDTH-1:0] acc_hi;
    logic                       acc_wr;
    logic                       unused_addr_bits;

    assign req      = i_Sig_Memory_Read_Enable | i_Sig_Memory_Write_Enable;
    assign in_phase = (state == LOW) || (state == HIGH);

    // Wrapping subtraction; bits outside the SRAM word range are dropped.
    assign addr_offset      = i_Address - DATA_WIDTH'(BASE_ADDR);
    assign word_in          = addr_offset[ADDR_WIDTH:2];
    assign unused_addr_bits = ^{addr_offset[DATA_WIDTH-1:ADDR_WIDTH+1], addr_offset[1:0]};

    wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .i_Clear    (!in_phase || terminal),
        .i_Enable   (in_phase),
        .o_Terminal (terminal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req)      state_nxt = LOW;
            LOW:     if (terminal) state_nxt = HIGH;
            HIGH:    if (terminal) state_nxt = DONE;
            DONE:                  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    assign o_Freeze = in_phase || (state == IDLE && req);

    // SRAM strobes are registered and change only at phase boundaries, so
    // WE_N/OE stay steady across LOW->HIGH and never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_word              <= '0;
            acc_hi                <= '0;
            acc_wr                <= 1'b0;
            o_Read_Data           <= '0;
            o_SRAM_Address        <= '0;
            o_SRAM_Data_Out       <= '0;
            o_SRAM_Write_Enable_N <= 1'b1;
            o_SRAM_Data_Oe        <= 1'b0;
        end else if (state == IDLE && req) begin
            acc_word              <= word_in;
            acc_hi                <= i_Write_Data[DATA_WIDTH-1:SRAM_DATA_WIDTH];
            acc_wr                <= i_Sig_Memory_Write_Enable;
            o_SRAM_Address        <= {word_in, 1'b0};
            o_SRAM_Data_Out       <= i_Write_Data[SRAM_DATA_WIDTH-1:0];
            o_SRAM_Write_Enable_N <= !i_Sig_Memory_Write_Enable;
            o_SRAM_Data_Oe        <= i_Sig_Memory_Write_Enable;
        end else if (state == LOW && terminal) begin
            o_SRAM_Address  <= {acc_word, 1'b1};
            o_SRAM_Data_Out <= acc_hi;
            if (!acc_wr)
                o_Read_Data[SRAM_DATA_WIDTH-1:0] <= i_SRAM_Data_In;
        end else if (state == HIGH && terminal) begin
            o_SRAM_Write_Enable_N <= 1'b1;
            o_SRAM_Data_Oe        <= 1'b0;
            if (!acc_wr)
                o_Read_Data[DATA_WIDTH-1:SRAM_DATA_WIDTH] <= i_SRAM_Data_In;
        end
    end
endmodule
